// File: rtl/instr_mem_loader_pkg.sv
// Shared types for the instruction memory loader.
// State encoding and word geometry constants.
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_e;

  localparam int NIBBLES_PER_WORD = 8;
  localparam int WORD_BYTES       = 4;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Loader bus: session control, nibble stream, RAM write port, status.
// slave = loader side, master = host/switch side.
interface instr_mem_loader_if;

  logic        start;
  logic [5:0]  load_words;
  logic        abort;
  logic [3:0]  nibble_in;
  logic        nibble_valid;
  logic        nibble_ready;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;

  modport slave (
    input  start, load_words, abort,
    input  nibble_in, nibble_valid,
    output nibble_ready,
    output mem_wr_en, mem_addr, mem_wr_data,
    output cpu_hold, busy, done, err, checksum
  );

  modport master (
    output start, load_words, abort,
    output nibble_in, nibble_valid,
    input  nibble_ready,
    input  mem_wr_en, mem_addr, mem_wr_data,
    input  cpu_hold, busy, done, err, checksum
  );

endinterface

// File: rtl/instr_mem_loader_nibble_packer.sv
// MSB-first nibble shift register with a 3-bit nibble counter.
// Ports: clear, shift_en, nibble_in in; word_ready, word_next out.
module instr_mem_loader_nibble_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [3:0]  nibble_in,
  output logic        word_ready,
  output logic [31:0] word_next
);

  logic [31:0] shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;

  // word_next is the word as it stands once this nibble lands
  assign word_next  = {shift_q[27:0], nibble_in};
  assign word_ready = shift_en &
    (cnt_q == 3'(NIBBLES_PER_WORD - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = word_next;
      cnt_d   = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads nibble-assembled words into instruction RAM, holding the CPU.
// Ports: clk, rst_n, bus (slave: control, nibbles, RAM write, status).
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_mem_loader_if.slave bus
);

  localparam logic [6:0] DEPTH_LIM = 7'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [5:0]  idx_q, idx_d;
  logic        rdy_q, rdy_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] csum_q, csum_d;

  logic        take;
  logic        pk_clear;
  logic        word_ready;
  logic [31:0] word_next;
  logic        len_ok;

  // rdy_q is only ever set in COLLECT
  assign take   = bus.nibble_valid & rdy_q;
  assign len_ok = (bus.load_words != 6'd0) &&
    ({1'b0, bus.load_words} <= DEPTH_LIM);

  instr_mem_loader_nibble_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .shift_en   (take),
    .nibble_in  (bus.nibble_in),
    .word_ready (word_ready),
    .word_next  (word_next)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    rdy_d    = rdy_q;
    wr_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    csum_d   = csum_q;
    pk_clear = 1'b0;
    if (state_q != S_IDLE && bus.abort) begin
      state_d  = S_IDLE;
      rdy_d    = 1'b0;
      busy_d   = 1'b0;
      pk_clear = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            if (len_ok) begin
              state_d  = S_COLLECT;
              count_d  = bus.load_words;
              idx_d    = '0;
              csum_d   = '0;
              rdy_d    = 1'b1;
              busy_d   = 1'b1;
              pk_clear = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_COLLECT: begin
          // write strobe and checksum land together on WRITE entry
          if (word_ready) begin
            state_d = S_WRITE;
            rdy_d   = 1'b0;
            wr_d    = 1'b1;
            addr_d  = BASE_ADDR +
              32'(idx_q) * 32'(WORD_BYTES);
            data_d  = word_next;
            csum_d  = csum_q ^ word_next;
          end
        end
        S_WRITE: begin
          pk_clear = 1'b1;
          if (idx_q == count_q - 6'd1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_COLLECT;
            idx_d   = idx_q + 6'd1;
            rdy_d   = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      rdy_q   <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      rdy_q   <= rdy_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      csum_q  <= csum_d;
    end
  end

  assign bus.nibble_ready = rdy_q;
  assign bus.mem_wr_en    = wr_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wr_data  = data_q;
  assign bus.cpu_hold     = busy_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.checksum     = csum_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboarded random bench for instr_mem_loader.
// Stimulus queues expected writes; a negedge monitor checks them.
`timescale 1ns/100ps
module tb_instr_mem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_loader_if bus ();

  instr_mem_loader #(
    .DEPTH_WORDS (32),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic prev_wr = 1'b0;
  logic [63:0] exp_q [$];
  logic [63:0] mon_e;
  logic [31:0] words [32];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  // monitor: pops the scoreboard on every write strobe
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_wr_en) begin
        wr_cnt++;
        chk("ready_low_in_write", 32'(bus.nibble_ready), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: addr %h data %h, none expected",
                   bus.mem_addr, bus.mem_wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", bus.mem_addr, mon_e[63:32]);
          chk("wr_data", bus.mem_wr_data, mon_e[31:0]);
        end
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_after_write", 32'(prev_wr), 1);
      end
      if (bus.err) err_cnt++;
      prev_wr = bus.mem_wr_en;
    end else begin
      prev_wr = 1'b0;
    end
  end

  // gap: 0 back-to-back, 1 alternate idle cycles, 2 random idles
  task automatic send_nibs(input logic [31:0] w,
                           input int cnt, input int gap);
    int to;
    bit g;
    for (int i = 0; i < cnt; i++) begin
      g = (gap == 1) || (gap == 2 && $urandom_range(0, 1) == 1);
      if (g) begin
        bus.nibble_valid = 1'b0;
        @(negedge clk);
      end
      bus.nibble_valid = 1'b1;
      bus.nibble_in    = w[31 - 4*i -: 4];
      to = 0;
      while (!bus.nibble_ready && to < 40) begin
        @(negedge clk);
        to++;
      end
      if (to >= 40) begin
        n_checks++;
        $display("FAIL nibble_ready_timeout: got 0 expected 1");
      end
      @(negedge clk);
    end
    bus.nibble_valid = 1'b0;
  endtask

  task automatic start_session(input int n);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.load_words = 6'(n);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("hold_after_start", 32'(bus.cpu_hold), 1);
  endtask

  task automatic session(input int n, input int gap);
    int d0, w0, to;
    logic [31:0] x;
    d0 = done_cnt;
    w0 = wr_cnt;
    x  = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({BASE + 32'(4*i), words[i]});
      x ^= words[i];
    end
    start_session(n);
    for (int i = 0; i < n; i++) send_nibs(words[i], 8, gap);
    to = 0;
    while (done_cnt == d0 && to < 30) begin
      @(negedge clk);
      to++;
    end
    chk("done_count", 32'(done_cnt - d0), 1);
    @(negedge clk);
    chk("write_count", 32'(wr_cnt - w0), 32'(n));
    chk("busy_after_done", 32'(bus.busy), 0);
    chk("hold_after_done", 32'(bus.cpu_hold), 0);
    chk("checksum", bus.checksum, x);
    chk("addr_hold", bus.mem_addr, BASE + 32'(4*(n-1)));
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.nibble_ready), 0);
    chk({tag, "_wr_en"}, 32'(bus.mem_wr_en), 0);
    chk({tag, "_hold"}, 32'(bus.cpu_hold), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_addr"}, bus.mem_addr, BASE);
    chk({tag, "_data"}, bus.mem_wr_data, 0);
    chk({tag, "_csum"}, bus.checksum, 0);
  endtask

  initial begin
    int d0, w0, e0;
    bus.start        = 1'b0;
    bus.load_words   = '0;
    bus.abort        = 1'b0;
    bus.nibble_in    = '0;
    bus.nibble_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // basic single word
    words[0] = 32'h2008_0005;
    session(1, 0);

    // three words, valid toggling
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333;
    session(3, 1);

    // rejected lengths, and start masked by abort
    w0 = wr_cnt;
    e0 = err_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.load_words = 6'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("err_len0", 32'(bus.err), 1);
    chk("busy_len0", 32'(bus.busy), 0);
    @(negedge clk);
    chk("err_pulse_len0", 32'(bus.err), 0);
    bus.start = 1'b1;
    bus.load_words = 6'd33;
    @(negedge clk);
    bus.start = 1'b0;
    chk("err_len33", 32'(bus.err), 1);
    chk("busy_len33", 32'(bus.busy), 0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.load_words = 6'd1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", 32'(bus.busy), 0);
    chk("start_abort_err", 32'(bus.err), 0);
    repeat (2) @(negedge clk);
    chk("reject_no_write", 32'(wr_cnt - w0), 0);
    chk("reject_err_count", 32'(err_cnt - e0), 2);

    // abort after one word plus three nibbles
    words[0] = $urandom;
    words[1] = $urandom;
    d0 = done_cnt;
    w0 = wr_cnt;
    exp_q.push_back({BASE, words[0]});
    start_session(2);
    send_nibs(words[0], 8, 2);
    send_nibs(words[1], 3, 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_ready", 32'(bus.nibble_ready), 0);
    chk("abort_csum", bus.checksum, words[0]);
    repeat (3) @(negedge clk);
    chk("abort_writes", 32'(wr_cnt - w0), 1);
    chk("abort_no_done", 32'(done_cnt - d0), 0);

    // async reset between edges mid-collect
    words[0] = $urandom;
    start_session(2);
    send_nibs(words[0], 4, 0);
    #2 rst_n = 1'b0;
    #0.5 chk_reset_vals("async");
    #0.5 rst_n = 1'b1;
    @(negedge clk);
    words[0] = $urandom;
    session(1, 2);

    // full depth, random words
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    session(32, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side companion to the multicycle CPU's instruction memory: assembles 32-bit instructions from a 4-bit nibble stream (board switches or host) and writes them word by word into the instruction RAM.
- Holds the CPU stalled (cpu_hold) while loading and reports completion plus a running checksum.
- Sits between the input-select/switch logic and the instruction memory write port; the read side is unchanged.

Parameters:
- DEPTH_WORDS, 32, instruction memory depth in words; the read side indexes with address[6:2].
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be word aligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a load session; sampled in IDLE only.
- load_words  input  6  words to load, 1..DEPTH_WORDS; latched on accepted start.
- abort  input  1  cancel the session; highest priority after reset.
- nibble_in  input  4  instruction nibble, MSB-first within a word.
- nibble_valid  input  1  nibble_in valid this cycle.
- nibble_ready  output  1  loader accepts a nibble this cycle.
- mem_wr_en  output  1  one-cycle write strobe to the instruction RAM.
- mem_addr  output  32  byte address of the write, word aligned.
- mem_wr_data  output  32  assembled instruction.
- cpu_hold  output  1  stall the CPU/PC while a session is active.
- busy  output  1  session in progress (state != IDLE).
- done  output  1  one-cycle pulse when the last word has been written.
- err  output  1  one-cycle pulse when start is rejected.
- checksum  output  32  XOR of all words written in the current or last session.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; nibble_ready, mem_wr_en, cpu_hold, busy, done, err = 0; mem_addr=BASE_ADDR; mem_wr_data=0; checksum=0. Internal counters are cleared.
- States: IDLE, COLLECT, WRITE, DONE. All outputs are registered.
- IDLE:
  - start=1 with load_words in 1..DEPTH_WORDS: latch count, clear word_idx, nib_cnt and checksum, go to COLLECT.
  - start=1 with load_words=0 or load_words>DEPTH_WORDS: err pulses for one cycle; stay in IDLE.
- COLLECT:
  - nibble_ready=1.
  - On each cycle with nibble_valid & nibble_ready: shift_reg <= {shift_reg[27:0], nibble_in}; nib_cnt++.
  - When the 8th nibble is accepted, go to WRITE on the next edge. nibble_ready is 0 from that edge on, so no 9th nibble can be taken.
- WRITE (exactly 1 cycle):
  - mem_wr_en=1, mem_addr=BASE_ADDR+4*word_idx, mem_wr_data=shift_reg.
  - checksum ^= shift_reg; nib_cnt cleared.
  - If word_idx==count-1, go to DONE; otherwise word_idx++ and return to COLLECT.
- DONE (1 cycle): done=1, then IDLE.
- cpu_hold=busy: asserted from the cycle after start is accepted through the DONE cycle.
- Latency: first nibble to first write strobe is at least 9 cycles with back-to-back valid nibbles. A full session of N words takes 9N+1 cycles after COLLECT entry.
- Address arithmetic: mem_addr is 32-bit; the word offset never exceeds 4*(DEPTH_WORDS-1), so it does not wrap.
- mem_addr and mem_wr_data hold their last values outside WRITE. mem_wr_en is the only qualifier.
- abort=1 in any non-IDLE state: go to IDLE next edge. The partial word is discarded, no write or done is issued, and checksum keeps the XOR of the words already written.
- abort and start both high in IDLE: start is ignored.
- start while busy: ignored.
- nibble_valid outside COLLECT: ignored; nibble_ready=0.
- Reset mid-session: immediate return to reset values. Words already written remain in the RAM.

Decomposition:
- Shared package holds the state enum (IDLE/COLLECT/WRITE/DONE), NIBBLES_PER_WORD=8 and WORD_BYTES=4.
- One natural sub-module, nibble_packer: shift register plus 3-bit counter, with word_ready output and clear input. The FSM, address and checksum logic stay in the top module.

Test Plan:
- Basic load: load_words=1, nibbles 2,0,0,8,0,0,0,5 back-to-back -> exactly one mem_wr_en pulse with mem_addr=0x0 and mem_wr_data=0x20080005; done 1 cycle later; checksum=0x20080005; cpu_hold drops after DONE.
- Multi-word with gaps: load_words=3, words 0x11111111, 0x22222222, 0x33333333, with nibble_valid toggling every other cycle -> writes at 0x0, 0x4, 0x8 in order; checksum=0x00000000; nibble_ready never high in WRITE.
- Reject: start with load_words=0, then with load_words=33 -> err pulses each time; busy stays 0; no write.
- Abort: load_words=2, abort after 1 full word plus 3 nibbles -> one write only, no done; busy=0 the next cycle; checksum equals the first word.
- Async reset: rst_n low for 1 ns mid-COLLECT, between clock edges -> all outputs reach reset values immediately; a new session then writes from BASE_ADDR.
- Full depth: load_words=32 with random words -> last write at mem_addr=0x7C; 32 strobes total; checksum matches the XOR of the model's words.
